// File: rtl/trade_pkg.sv
// Shared definitions for the trading signal path.
//   - Signal encodings carried on in_signal (BUY/SELL/HOLD, 2'b10 reserved).
//   - Position encodings used for the committed and target positions.
//   - Order FSM state type.
//   - Price width (Q16.16).
//   - Helpers that classify a signal and map it to the position it asks for.
package trade_pkg;

    localparam int unsigned PRICE_W = 32;

    localparam logic [1:0] SIG_HOLD = 2'b00;
    localparam logic [1:0] SIG_BUY  = 2'b01;
    localparam logic [1:0] SIG_RSVD = 2'b10;
    localparam logic [1:0] SIG_SELL = 2'b11;

    localparam logic [1:0] POS_FLAT  = 2'b00;
    localparam logic [1:0] POS_LONG  = 2'b01;
    localparam logic [1:0] POS_SHORT = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StSend = 2'b01,
        StCool = 2'b10
    } state_e;

    // True for signals that request a position (BUY or SELL).
    function automatic logic is_action(input logic [1:0] sig);
        return (sig == SIG_BUY) || (sig == SIG_SELL);
    endfunction

    // Position an action signal asks for; only meaningful when is_action(sig).
    function automatic logic [1:0] sig_to_pos(input logic [1:0] sig);
        return (sig == SIG_BUY) ? POS_LONG : POS_SHORT;
    endfunction

endpackage

// File: rtl/signal_order_gen_if.sv
// Bundle between the signal generator, the order generator and the order gateway.
//   in_valid/in_signal/in_price : signal tick from the EMA crossover pipeline
//   ord_valid/ord_ready         : order request handshake towards the gateway
//   ord_side/ord_qty/ord_price  : order fields, frozen while ord_valid is high
//   position/drop_cnt           : committed position and dropped-action count
// Modports: slave = the order generator, master = its environment.
interface signal_order_gen_if;
    import trade_pkg::*;

    logic               in_valid;
    logic [1:0]         in_signal;
    logic [PRICE_W-1:0] in_price;
    logic               ord_valid;
    logic               ord_ready;
    logic               ord_side;
    logic [15:0]        ord_qty;
    logic [PRICE_W-1:0] ord_price;
    logic [1:0]         position;
    logic [15:0]        drop_cnt;

    modport master (
        output in_valid, in_signal, in_price, ord_ready,
        input  ord_valid, ord_side, ord_qty, ord_price, position, drop_cnt
    );

    modport slave (
        input  in_valid, in_signal, in_price, ord_ready,
        output ord_valid, ord_side, ord_qty, ord_price, position, drop_cnt
    );

endinterface

// File: rtl/signal_order_gen_debounce.sv
// Streak tracker: counts consecutive identical BUY/SELL ticks and flags the
// tick on which the streak reaches CONFIRM_N (and every identical tick after).
//   clk, rst      : clock, synchronous active-high reset
//   in_valid_i    : tick valid
//   in_signal_i   : tick signal encoding
//   confirmed_o   : this tick is a confirmed BUY/SELL (combinational)
//   desired_o     : position requested by this tick (valid with confirmed_o)
module signal_debounce
    import trade_pkg::*;
#(
    parameter int unsigned CONFIRM_N = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid_i,
    input  logic [1:0] in_signal_i,
    output logic       confirmed_o,
    output logic [1:0] desired_o
);

    localparam logic [3:0] CntMax = 4'(CONFIRM_N);

    logic [1:0] last_sig_q, last_sig_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        last_sig_d = last_sig_q;
        cnt_d      = cnt_q;
        if (in_valid_i) begin
            if (is_action(in_signal_i)) begin
                if (in_signal_i == last_sig_q) begin
                    // Saturate so a persisting signal keeps confirming.
                    cnt_d = (cnt_q >= CntMax) ? CntMax : cnt_q + 4'd1;
                end else begin
                    last_sig_d = in_signal_i;
                    cnt_d      = 4'd1;
                end
            end else begin
                // HOLD or reserved breaks the streak but keeps last_sig.
                cnt_d = 4'd0;
            end
        end
    end

    // Confirmation uses the updated count so the FSM acts on the same edge.
    assign confirmed_o = in_valid_i && is_action(in_signal_i) && (cnt_d == CntMax);
    assign desired_o   = sig_to_pos(in_signal_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_sig_q <= SIG_HOLD;
            cnt_q      <= 4'd0;
        end else begin
            last_sig_q <= last_sig_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: rtl/signal_order_gen.sv
// Order generator: turns debounced BUY/SELL signals into order requests.
// Tracks the committed position, issues one order per position change over a
// valid/ready handshake, holds off for COOLDOWN cycles after each acceptance
// and counts confirmed actions that arrive while busy.
//   clk, rst : clock, synchronous active-high reset
//   bus      : signal_order_gen_if.slave (tick input, order output, status)
module signal_order_gen
    import trade_pkg::*;
#(
    parameter int unsigned CONFIRM_N = 2,
    parameter int unsigned COOLDOWN  = 16,
    parameter int unsigned QTY       = 100
) (
    input logic               clk,
    input logic               rst,
    signal_order_gen_if.slave bus
);

    localparam logic [15:0] QtyOne   = 16'(QTY);
    localparam logic [15:0] QtyTwo   = 16'(2 * QTY);
    // Counter runs CoolLoad..0, giving exactly COOLDOWN cycles in StCool.
    localparam logic [15:0] CoolLoad = (COOLDOWN == 0) ? 16'd0 : 16'(COOLDOWN - 1);

    state_e             state_q, state_d;
    logic [1:0]         tgt_pos_q, tgt_pos_d;
    logic [1:0]         position_q, position_d;
    logic               ord_valid_q, ord_valid_d;
    logic               ord_side_q, ord_side_d;
    logic [15:0]        ord_qty_q, ord_qty_d;
    logic [PRICE_W-1:0] ord_price_q, ord_price_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic [15:0]        cool_cnt_q, cool_cnt_d;

    logic       confirmed;
    logic [1:0] desired;
    logic       wants_change;
    logic       issue;
    logic       drop;
    logic       handshake;

    signal_debounce #(
        .CONFIRM_N (CONFIRM_N)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (bus.in_valid),
        .in_signal_i (bus.in_signal),
        .confirmed_o (confirmed),
        .desired_o   (desired)
    );

    // Compare against tgt_pos so a tick matching a pending order is a no-op.
    assign wants_change = confirmed && (desired != tgt_pos_q);
    assign issue        = wants_change && (state_q == StIdle);
    assign drop         = wants_change && (state_q != StIdle);
    assign handshake    = ord_valid_q && bus.ord_ready;

    // State and order registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tgt_pos_q   <= POS_FLAT;
            position_q  <= POS_FLAT;
            ord_valid_q <= 1'b0;
            ord_side_q  <= 1'b0;
            ord_qty_q   <= 16'd0;
            ord_price_q <= '0;
            drop_cnt_q  <= 16'd0;
            cool_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            tgt_pos_q   <= tgt_pos_d;
            position_q  <= position_d;
            ord_valid_q <= ord_valid_d;
            ord_side_q  <= ord_side_d;
            ord_qty_q   <= ord_qty_d;
            ord_price_q <= ord_price_d;
            drop_cnt_q  <= drop_cnt_d;
            cool_cnt_q  <= cool_cnt_d;
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (issue) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (handshake) begin
                    state_d = (COOLDOWN == 0) ? StIdle : StCool;
                end
            end
            StCool: begin
                if (cool_cnt_q == 16'd0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the order, position and counter registers.
    always_comb begin
        tgt_pos_d   = tgt_pos_q;
        position_d  = position_q;
        ord_valid_d = ord_valid_q;
        ord_side_d  = ord_side_q;
        ord_qty_d   = ord_qty_q;
        ord_price_d = ord_price_q;
        drop_cnt_d  = drop_cnt_q;
        cool_cnt_d  = cool_cnt_q;

        if (issue) begin
            ord_valid_d = 1'b1;
            ord_side_d  = (desired == POS_SHORT);
            // Reversing needs to close the old position and open the new one.
            ord_qty_d   = (position_q == POS_FLAT) ? QtyOne : QtyTwo;
            ord_price_d = bus.in_price;
            tgt_pos_d   = desired;
        end

        if ((state_q == StSend) && handshake) begin
            ord_valid_d = 1'b0;
            position_d  = tgt_pos_q;
            cool_cnt_d  = CoolLoad;
        end

        if ((state_q == StCool) && (cool_cnt_q != 16'd0)) begin
            cool_cnt_d = cool_cnt_q - 16'd1;
        end

        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    assign bus.ord_valid = ord_valid_q;
    assign bus.ord_side  = ord_side_q;
    assign bus.ord_qty   = ord_qty_q;
    assign bus.ord_price = ord_price_q;
    assign bus.position  = position_q;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_signal_order_gen.sv
// Bench for signal_order_gen: directed tick sequences, a behavioural model
// checked every cycle, and literal expectations at key points.
module tb_signal_order_gen;
    import trade_pkg::*;

    localparam int unsigned TbConfirm  = 2;
    localparam int unsigned TbCooldown = 16;
    localparam int unsigned TbQty      = 100;

    logic clk;
    logic rst;
    logic rdy;
    int   n_cmp;
    int   n_fail;

    signal_order_gen_if bus ();

    signal_order_gen #(
        .CONFIRM_N (TbConfirm),
        .COOLDOWN  (TbCooldown),
        .QTY       (TbQty)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Streak kept as an unbounded run length; cooldown kept as the first edge
    // index at which a new order may be issued.
    longint      edge_no;
    longint      m_idle_from;
    int          m_run;
    logic [1:0]  m_last;
    logic        m_valid;
    logic        m_side;
    logic [15:0] m_qty;
    logic [31:0] m_price;
    logic [1:0]  m_pos;
    logic [1:0]  m_pend;
    logic [15:0] m_drop;
    logic        m_conf;
    logic        m_busy;
    logic [1:0]  m_want;
    logic [1:0]  m_target;

    initial edge_no = 0;

    always @(posedge clk) begin
        edge_no = edge_no + 1;
        if (rst) begin
            m_valid     = 1'b0;
            m_side      = 1'b0;
            m_qty       = 16'd0;
            m_price     = 32'd0;
            m_pos       = POS_FLAT;
            m_pend      = POS_FLAT;
            m_drop      = 16'd0;
            m_last      = SIG_HOLD;
            m_run       = 0;
            m_idle_from = 0;
        end else begin
            m_conf = 1'b0;
            m_want = POS_FLAT;
            if (bus.in_valid) begin
                if (bus.in_signal == SIG_BUY || bus.in_signal == SIG_SELL) begin
                    m_run  = (bus.in_signal == m_last) ? m_run + 1 : 1;
                    m_last = bus.in_signal;
                    m_conf = (m_run >= int'(TbConfirm));
                    m_want = (bus.in_signal == SIG_BUY) ? POS_LONG : POS_SHORT;
                end else begin
                    m_run = 0;
                end
            end
            m_busy   = m_valid || (edge_no < m_idle_from);
            m_target = m_valid ? m_pend : m_pos;
            if (m_valid && bus.ord_ready) begin
                m_valid     = 1'b0;
                m_pos       = m_pend;
                m_idle_from = edge_no + longint'(TbCooldown) + 1;
            end
            if (m_conf && (m_want != m_target)) begin
                if (m_busy) begin
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end else begin
                    m_valid = 1'b1;
                    m_side  = (m_want == POS_SHORT);
                    m_qty   = (m_pos == POS_FLAT) ? 16'(TbQty) : 16'(2 * TbQty);
                    m_price = bus.in_price;
                    m_pend  = m_want;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(posedge clk) begin
        #2;
        chk("mdl_ord_valid", 32'(bus.ord_valid), 32'(m_valid));
        chk("mdl_position", 32'(bus.position), 32'(m_pos));
        chk("mdl_drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
        if (m_valid) begin
            chk("mdl_ord_side", 32'(bus.ord_side), 32'(m_side));
            chk("mdl_ord_qty", 32'(bus.ord_qty), 32'(m_qty));
            chk("mdl_ord_price", bus.ord_price, m_price);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic [1:0] s, input logic [31:0] p);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_signal = s;
        bus.in_price  = p;
        bus.ord_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, SIG_HOLD, 32'd0);
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        rst           = 1'b1;
        rdy           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_signal = SIG_HOLD;
        bus.in_price  = 32'd0;
        bus.ord_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ord_valid", 32'(bus.ord_valid), 32'd0);
        chk("rst_ord_side", 32'(bus.ord_side), 32'd0);
        chk("rst_ord_qty", 32'(bus.ord_qty), 32'd0);
        chk("rst_ord_price", bus.ord_price, 32'd0);
        chk("rst_position", 32'(bus.position), 32'd0);
        chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // FLAT -> LONG, order raised right after the second BUY.
        rdy = 1'b1;
        step(1'b1, SIG_BUY, 32'h0001_0000);
        chk("buy1_no_order", 32'(bus.ord_valid), 32'd0);
        step(1'b1, SIG_BUY, 32'h0002_8000);
        chk("buy_valid", 32'(bus.ord_valid), 32'd1);
        chk("buy_side", 32'(bus.ord_side), 32'd0);
        chk("buy_qty", 32'(bus.ord_qty), 32'd100);
        chk("buy_price", bus.ord_price, 32'h0002_8000);
        idle(1);
        chk("buy_accept_valid", 32'(bus.ord_valid), 32'd0);
        chk("buy_accept_pos", 32'(bus.position), 32'(POS_LONG));
        idle(17);

        // BUY while already LONG: no order, no drop.
        step(1'b1, SIG_BUY, 32'h0002_0000);
        chk("noop_valid", 32'(bus.ord_valid), 32'd0);
        chk("noop_drop", 32'(bus.drop_cnt), 32'd0);

        // LONG -> SHORT reversal, double quantity.
        step(1'b1, SIG_SELL, 32'h0003_0000);
        step(1'b1, SIG_SELL, 32'h0003_1000);
        chk("sell_valid", 32'(bus.ord_valid), 32'd1);
        chk("sell_side", 32'(bus.ord_side), 32'd1);
        chk("sell_qty", 32'(bus.ord_qty), 32'd200);
        idle(1);
        chk("sell_accept_pos", 32'(bus.position), 32'(POS_SHORT));
        idle(17);

        // Broken streak, then a held-off handshake with changing prices.
        step(1'b1, SIG_BUY, 32'h0001_0000);
        step(1'b1, SIG_HOLD, 32'h0001_1000);
        step(1'b1, SIG_BUY, 32'h0001_2000);
        chk("broken_streak_valid", 32'(bus.ord_valid), 32'd0);
        rdy = 1'b0;
        step(1'b1, SIG_BUY, 32'h0003_4000);
        chk("stall_valid", 32'(bus.ord_valid), 32'd1);
        chk("stall_qty", 32'(bus.ord_qty), 32'd200);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, SIG_HOLD, 32'h0004_0000 + 32'(i));
            chk("stall_hold_valid", 32'(bus.ord_valid), 32'd1);
            chk("stall_hold_price", bus.ord_price, 32'h0003_4000);
        end
        rdy = 1'b1;
        idle(1);
        chk("stall_accept_valid", 32'(bus.ord_valid), 32'd0);
        chk("stall_accept_pos", 32'(bus.position), 32'(POS_LONG));

        // SELL x3 right after acceptance (in cooldown): second and third drop.
        step(1'b1, SIG_SELL, 32'h0005_0000);
        step(1'b1, SIG_SELL, 32'h0005_1000);
        step(1'b1, SIG_SELL, 32'h0005_2000);
        chk("cool_drop_cnt", 32'(bus.drop_cnt), 32'd2);
        chk("cool_no_order", 32'(bus.ord_valid), 32'd0);
        // Cooldown ends after edge a+16; the SELL at edge a+17 is the first in idle.
        idle(13);
        step(1'b1, SIG_SELL, 32'h0006_0000);
        chk("post_cool_valid", 32'(bus.ord_valid), 32'd1);
        chk("post_cool_side", 32'(bus.ord_side), 32'd1);
        chk("post_cool_qty", 32'(bus.ord_qty), 32'd200);
        chk("post_cool_drop", 32'(bus.drop_cnt), 32'd2);
        idle(1);
        chk("post_cool_pos", 32'(bus.position), 32'(POS_SHORT));
        idle(17);

        // Reset while an order is pending.
        rdy = 1'b0;
        step(1'b1, SIG_BUY, 32'h0007_0000);
        step(1'b1, SIG_BUY, 32'h0007_1000);
        chk("pre_rst_valid", 32'(bus.ord_valid), 32'd1);
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 32'(bus.ord_valid), 32'd0);
        chk("mid_rst_pos", 32'(bus.position), 32'd0);
        chk("mid_rst_drop", 32'(bus.drop_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rdy = 1'b1;

        // Reserved encoding breaks the streak; fresh order from FLAT is QTY.
        step(1'b1, SIG_BUY, 32'h0008_0000);
        step(1'b1, SIG_RSVD, 32'h0008_1000);
        step(1'b1, SIG_BUY, 32'h0008_2000);
        chk("rsvd_no_order", 32'(bus.ord_valid), 32'd0);
        step(1'b1, SIG_BUY, 32'h0008_3000);
        chk("flat_buy_valid", 32'(bus.ord_valid), 32'd1);
        chk("flat_buy_qty", 32'(bus.ord_qty), 32'd100);
        chk("flat_buy_price", bus.ord_price, 32'h0008_3000);
        idle(1);
        chk("flat_buy_pos", 32'(bus.position), 32'(POS_LONG));
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
